// File: rtl/button_debounce_pulse_if.sv
// Button conditioning port bundle: raw input and enable in,
// debounced level and press/repeat pulse out.
interface button_debounce_pulse_if;
   logic en;
   logic btn_in;
   logic btn_level;
   logic btn_pulse;

   modport master (
      output en,
      output btn_in,
      input  btn_level,
      input  btn_pulse
   );

   modport slave (
      input  en,
      input  btn_in,
      output btn_level,
      output btn_pulse
   );
endinterface

// File: rtl/button_debounce_pulse.sv
// Push-button synchroniser + debouncer with one-cycle press pulses
// and optional auto-repeat while the button is held.
module button_debounce_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   button_debounce_pulse_if.slave   bus
);

   localparam int unsigned CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HMAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HW = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
   localparam logic [HW-1:0] HOLD_TOP = '1;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic          s0_q, btn_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          phase_q, phase_d;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;
   logic [HW-1:0] hold_last;

   // phase_q=0 waits out the initial delay, 1 the repeat period
   assign hold_last = phase_q ? PER_LAST : DLY_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q    <= 1'b0;
         btn_s_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         phase_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s0_q    <= bus.btn_in;
         btn_s_q <= s0_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         phase_q <= phase_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      phase_d = phase_q;
      level_d = level_q;
      pulse_d = 1'b0;

      if (!bus.en) begin
         state_d = IDLE;
         cnt_d   = '0;
         hold_d  = '0;
         phase_d = 1'b0;
         level_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               level_d = 1'b0;
               if (btn_s_q) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = HELD;
                  hold_d  = '0;
                  phase_d = 1'b0;
                  level_d = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!btn_s_q) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = '0;
               end else if (REPEAT_EN != 0 && hold_q == hold_last) begin
                  pulse_d = 1'b1;
                  hold_d  = '0;
                  phase_d = 1'b1;
               end else if (hold_q != HOLD_TOP) begin
                  hold_d = hold_q + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               // a bounce back high resumes the repeat schedule in place
               if (btn_s_q) begin
                  state_d = HELD;
               end else if (cnt_q == DB_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  hold_d  = '0;
                  phase_d = 1'b0;
                  level_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.btn_level = level_q;
   assign bus.btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse: one repeat-enabled and
// one single-shot instance driven from the same button.
module tb_button_debounce_pulse;

   logic clk;
   logic rst;
   logic en;
   logic btn_in;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   int np_a = 0;
   int np_b = 0;
   int n_dbl = 0;
   int n_hi = 0;
   int n_lo = 0;
   int fall_cyc = -1;
   int pq[$];
   logic prev_p = 1'b0;
   logic prev_l = 1'b0;

   button_debounce_pulse_if bus_a ();
   button_debounce_pulse_if bus_b ();

   assign bus_a.en     = en;
   assign bus_a.btn_in = btn_in;
   assign bus_b.en     = en;
   assign bus_b.btn_in = btn_in;

   button_debounce_pulse #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) u_rep (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   button_debounce_pulse #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (0),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) u_one (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // cyc seen here is the index of the edge that produced the outputs
   always @(negedge clk) begin
      if (bus_a.btn_pulse) begin
         np_a++;
         pq.push_back(cyc);
         if (prev_p) n_dbl++;
      end
      prev_p = bus_a.btn_pulse;
      if (bus_b.btn_pulse) np_b++;
      if (prev_l && !bus_a.btn_level) fall_cyc = cyc;
      prev_l = bus_a.btn_level;
      if (bus_a.btn_level) n_hi++;
      else n_lo++;
   end

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int pq_at(input int i);
      return (pq.size() > i) ? pq[i] : -1;
   endfunction

   int s, r, e, p0, pb0, h0, l0;
   int offs [6] = '{0, 20, 28, 36, 44, 52};

   initial begin
      rst    = 1'b1;
      en     = 1'b1;
      btn_in = 1'b1;

      // reset wins over a held button and en=1
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("rst_level", bus_a.btn_level, 1'b0);
         check("rst_pulse", bus_a.btn_pulse, 1'b0);
      end
      rst    = 1'b0;
      btn_in = 1'b0;
      step(4);

      // clean press: pulse 6 edges after first sample
      p0 = np_a; pb0 = np_b;
      btn_in = 1'b1;
      s = cyc + 1;
      step(15);
      check("press_cnt", np_a - p0, 1);
      check("press_time", pq_at(p0), s + 6);
      check("press_level", bus_a.btn_level, 1'b1);
      check("press_cnt_one", np_b - pb0, 1);
      btn_in = 1'b0;
      step(10);
      check("rel_level", bus_a.btn_level, 1'b0);
      check("rel_nopulse", np_a - p0, 1);

      // 3-cycle high glitch from idle
      p0 = np_a; h0 = n_hi;
      btn_in = 1'b1;
      step(3);
      btn_in = 1'b0;
      step(10);
      check("glitch_hi_pulse", np_a - p0, 0);
      check("glitch_hi_level", n_hi - h0, 0);

      // 3-cycle low glitch while held
      p0 = np_a;
      btn_in = 1'b1;
      step(12);
      check("held_level", bus_a.btn_level, 1'b1);
      l0 = n_lo;
      btn_in = 1'b0;
      step(3);
      btn_in = 1'b1;
      step(10);
      check("glitch_lo_level", n_lo - l0, 0);
      check("glitch_lo_pulse", np_a - p0, 1);
      btn_in = 1'b0;
      step(10);

      // long hold: press + repeats, then timed release
      p0 = np_a; pb0 = np_b;
      btn_in = 1'b1;
      s = cyc + 1;
      step(60);
      btn_in = 1'b0;
      r = cyc + 1;
      step(10);
      check("rep_cnt", np_a - p0, 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("rep_time%0d", i), pq_at(p0 + i), s + 6 + offs[i]);
      check("rep_cnt_one", np_b - pb0, 1);
      check("rel_fall_time", fall_cyc, r + 6);
      check("no_double", n_dbl, 0);

      // en drop while held, then en back with button still held
      btn_in = 1'b1;
      step(12);
      check("en_held_level", bus_a.btn_level, 1'b1);
      en = 1'b0;
      step(1);
      check("en_off_level", bus_a.btn_level, 1'b0);
      check("en_off_pulse", bus_a.btn_pulse, 1'b0);
      step(2);
      p0 = np_a;
      en = 1'b1;
      e = cyc + 1;
      step(8);
      check("en_on_cnt", np_a - p0, 1);
      check("en_on_time", pq_at(p0), e + 4);
      btn_in = 1'b0;
      step(10);

      // reset in PRESS_WAIT discards press; re-debounce afterwards
      p0 = np_a;
      btn_in = 1'b1;
      step(3);
      rst = 1'b1;
      step(2);
      check("rst_mid_pulse", np_a - p0, 0);
      check("rst_mid_level", bus_a.btn_level, 1'b0);
      rst = 1'b0;
      e = cyc + 1;
      step(10);
      check("post_rst_cnt", np_a - p0, 1);
      check("post_rst_time", pq_at(p0), e + 6);
      btn_in = 1'b0;
      step(10);

      check("final_no_double", n_dbl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
